iram_prog_loader: RTL

//  Hardware program loader for the CPU instruction RAM. It accepts a framed byte stream over a

---
 rtl/iram_prog_loader_pkg.sv | 21 ++
 rtl/iram_prog_loader_byte_packer.sv | 40 ++++
 rtl/iram_prog_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/iram_prog_loader_pkg.sv
// Shared definitions for the iRAM program loader: widths and FSM state encodings.
// Optional checksum state is present only when LOADER_CSUM_EN is defined.
`timescale 1ns/1ps
package iram_prog_loader_pkg;

    localparam int IRAM_ADDR_W = 10;
    localparam int INSTR_W     = 32;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_HI = 3'd1,
        LDR_LEN_LO = 3'd2,
        LDR_DATA   = 3'd3,
`ifdef LOADER_CSUM_EN
        LDR_CSUM   = 3'd4,
`endif
        LDR_DONE   = 3'd5,
        LDR_ERR    = 3'd6
    } ldr_state_t;

endpackage

// File: rtl/iram_prog_loader_byte_packer.sv
// Packs bytes MSB-first into a 32-bit word; pulses o_word_valid the cycle after the 4th byte.
`timescale 1ns/1ps
module iram_prog_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_idx,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_word_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_valid && (r_cnt == 2'd3);
            if (i_valid) begin
                r_shift <= {r_shift[23:0], i_byte};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign o_byte_idx   = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

endmodule

// File: rtl/iram_prog_loader.sv
// Framed byte-stream loader into iRAM; holds the CPU in reset until a good load completes.
// Optional trailing XOR checksum byte is compiled in with LOADER_CSUM_EN.
`timescale 1ns/1ps
module iram_prog_loader
    import iram_prog_loader_pkg::*;
#(
    parameter int ADDR_W    = IRAM_ADDR_W,
    parameter int DATA_W    = INSTR_W,
    parameter int DEPTH     = 1024,
    parameter int BOOT_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ldr_state_t        r_state;
    ldr_state_t        w_next;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_rx_words;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_pack_valid;
    logic [1:0]        w_byte_idx;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [15:0]       w_len;
    logic              w_last_write;
`ifdef LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    assign w_accept     = in_valid & in_ready;
    assign w_start_ok   = start && (r_state == LDR_IDLE || r_state == LDR_DONE || r_state == LDR_ERR);
    assign w_pack_valid = w_accept && (r_state == LDR_DATA);
    assign w_len        = {r_len[15:8], in_byte};
    assign w_last_write = w_word_valid && (16'(r_wr_addr) == r_len - 16'd1);

    iram_prog_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_valid      (w_pack_valid),
        .i_byte       (in_byte),
        .o_byte_idx   (w_byte_idx),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= LDR_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b1;
        case (r_state)
            LDR_IDLE: begin
                busy    = 1'b0;
                cpu_rst = (BOOT_HOLD != 0);
                if (w_start_ok) w_next = LDR_LEN_HI;
            end
            LDR_LEN_HI: begin
                in_ready = 1'b1;
                if (w_accept) w_next = LDR_LEN_LO;
            end
            LDR_LEN_LO: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_len > 16'(DEPTH))  w_next = LDR_ERR;
`ifdef LOADER_CSUM_EN
                    else if (w_len == '0)    w_next = LDR_CSUM;
`else
                    else if (w_len == '0)    w_next = LDR_DONE;
`endif
                    else                     w_next = LDR_DATA;
                end
            end
            LDR_DATA: begin
                // stop taking bytes once the last word is in the packer
                in_ready = (16'(r_rx_words) != r_len);
`ifdef LOADER_CSUM_EN
                if (w_last_write) w_next = LDR_CSUM;
`else
                if (w_last_write) w_next = LDR_DONE;
`endif
            end
`ifdef LOADER_CSUM_EN
            LDR_CSUM: begin
                in_ready = 1'b1;
                if (w_accept) w_next = (in_byte == r_csum) ? LDR_DONE : LDR_ERR;
            end
`endif
            LDR_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (w_start_ok) w_next = LDR_LEN_HI;
            end
            LDR_ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (w_start_ok) w_next = LDR_LEN_HI;
            end
            default: w_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len      <= '0;
            r_wr_addr  <= '0;
            r_rx_words <= '0;
        end else if (w_start_ok) begin
            r_len      <= '0;
            r_wr_addr  <= '0;
            r_rx_words <= '0;
        end else begin
            if (w_accept && r_state == LDR_LEN_HI) r_len[15:8] <= in_byte;
            if (w_accept && r_state == LDR_LEN_LO) r_len[7:0]  <= in_byte;
            if (w_pack_valid && w_byte_idx == 2'd3) r_rx_words <= r_rx_words + 1'b1;
            // address holds on the final word so N == DEPTH cannot wrap it to 0
            if (w_word_valid && !w_last_write) r_wr_addr <= r_wr_addr + 1'b1;
        end
    end

`ifdef LOADER_CSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_csum <= '0;
        else if (w_start_ok)
            r_csum <= '0;
        else if (w_accept && (r_state == LDR_LEN_HI || r_state == LDR_LEN_LO || r_state == LDR_DATA))
            r_csum <= r_csum ^ in_byte;
    end
`endif

    assign wr_en   = w_word_valid;
    assign wr_addr = r_wr_addr;
    assign wr_data = DATA_W'(w_word);

endmodule
